// File: rtl/dot_acc64.sv
// Streaming dot-product accumulator: sums N unsigned 64-bit products into one SUM_W-bit result.
// Optional synchronous clear of the partial sum via port clr when DOT_ACC64_CLEAR_EN is defined.
module dot_acc64 #(
    parameter int N     = 4,
    parameter int SUM_W = 72
) (
    input  logic             clk,
    input  logic             rst,
`ifdef DOT_ACC64_CLEAR_EN
    input  logic             clr,
`endif
    input  logic [63:0]      product,
    input  logic             valid_in,
    output logic             in_ready,
    output logic [SUM_W-1:0] sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       elem_idx
);

    localparam logic [7:0] LAST_IDX = 8'(N - 1);

    logic [SUM_W-1:0] acc_q, acc_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [7:0]       elem_q, elem_d;
    logic             valid_q, valid_d;
    logic             last, accept, clr_act;
    logic [SUM_W-1:0] prod_ext;

`ifdef DOT_ACC64_CLEAR_EN
    assign clr_act = clr;
`else
    assign clr_act = 1'b0;
`endif

    assign prod_ext = {{(SUM_W - 64){1'b0}}, product};
    assign last     = (elem_q == LAST_IDX);

    // Handshake: a product transfers when valid_in && in_ready; a result transfers when
    // out_valid && out_ready. Only the final product stalls behind an unconsumed result.
    assign in_ready = rst && !clr_act && !(valid_q && !out_ready && last);
    assign accept   = valid_in && in_ready;

    always_comb begin
        acc_d   = acc_q;
        elem_d  = elem_q;
        sum_d   = sum_q;
        valid_d = valid_q;
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        if (clr_act) begin
            acc_d  = '0;
            elem_d = '0;
        end else if (accept) begin
            if (last) begin
                // Final product: publish and restart; overrides a same-cycle consume.
                sum_d   = acc_q + prod_ext;
                valid_d = 1'b1;
                acc_d   = '0;
                elem_d  = '0;
            end else if (elem_q == 8'd0) begin
                acc_d  = prod_ext;
                elem_d = elem_q + 8'd1;
            end else begin
                acc_d  = acc_q + prod_ext;
                elem_d = elem_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q   <= '0;
            elem_q  <= '0;
            sum_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            elem_q  <= elem_d;
            sum_q   <= sum_d;
            valid_q <= valid_d;
        end
    end

    assign sum       = sum_q;
    assign out_valid = valid_q;
    assign elem_idx  = elem_q;

endmodule

// File: tb/tb_dot_acc64.sv
// Directed bench for dot_acc64 (N=4): expected sums queued at issue, popped by a monitor on consume.
module tb_dot_acc64;

    localparam int SUM_W = 72;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic [63:0]      product;
    logic             valid_in;
    logic             in_ready;
    logic [SUM_W-1:0] sum;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       elem_idx;

    logic [SUM_W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    dot_acc64 #(.N(4), .SUM_W(SUM_W)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef DOT_ACC64_CLEAR_EN
        .clr       (clr),
`endif
        .product   (product),
        .valid_in  (valid_in),
        .in_ready  (in_ready),
        .sum       (sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .elem_idx  (elem_idx)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [SUM_W-1:0] act, input logic [SUM_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // driver: present one product and hold it until accepted
    task automatic send(input logic [63:0] p);
        int waited;
        waited   = 0;
        product  = p;
        valid_in = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("send_timeout", 72'(in_ready), 72'd1);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic send4(input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] c, input logic [63:0] d);
        exp_q.push_back(72'(a) + 72'(b) + 72'(c) + 72'(d));
        send(a); send(b); send(c); send(d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // scoreboard monitor: a result is consumed at the edge following a negedge with valid && ready
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", sum, 72'h0);
                if (sum == 72'h0) begin
                    failures++;
                    $display("FAIL unexpected_result: got 0x%0h expected none", sum);
                end
            end else begin
                check("sum", sum, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst       = 1'b0;
        clr       = 1'b0;
        product   = '0;
        valid_in  = 1'b0;
        out_ready = 1'b1;
        idle(2);
        @(negedge clk);
        check("rst_in_ready", 72'(in_ready), 72'd0);
        check("rst_out_valid", 72'(out_valid), 72'd0);
        check("rst_sum", sum, 72'd0);
        check("rst_elem_idx", 72'(elem_idx), 72'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // back-to-back 1..4, one-cycle pulse
        exp_q.push_back(72'd10);
        send(1); send(2); send(3); send(4);
        @(negedge clk);
        check("b2b_out_valid", 72'(out_valid), 72'd1);
        check("b2b_elem_idx", 72'(elem_idx), 72'd0);
        @(negedge clk);
        check("b2b_pulse_end", 72'(out_valid), 72'd0);
        #6;

        // max products
        send4(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        check("max_expected_const", exp_q[$], 72'h3_FFFF_FFFF_FFFF_FFFC);
        idle(2);

        // backpressure: hold 10, accept 5..7, stall 8
        out_ready = 1'b0;
        send4(1, 2, 3, 4);
        exp_q.push_back(72'd26);
        send(5); send(6); send(7);
        product  = 64'd8;
        valid_in = 1'b1;
        @(negedge clk);
        check("bp_in_ready_stall", 72'(in_ready), 72'd0);
        check("bp_hold_valid", 72'(out_valid), 72'd1);
        check("bp_hold_sum", sum, 72'd10);
        check("bp_elem_idx", 72'(elem_idx), 72'd3);
        @(posedge clk);
        #1;
        check("bp_still_stalled_valid", 72'(out_valid), 72'd1);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_release", 72'(in_ready), 72'd1);
        @(posedge clk);
        #1;
        valid_in  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_no_drop_valid", 72'(out_valid), 72'd1);
        check("bp_new_sum", sum, 72'd26);
        check("bp_elem_reset", 72'(elem_idx), 72'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        idle(2);

        // reset mid-accumulation
        send(7); send(9);
        @(negedge clk);
        check("mid_elem_idx", 72'(elem_idx), 72'd2);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_in_ready", 72'(in_ready), 72'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_elem_idx", 72'(elem_idx), 72'd0);
        check("post_rst_out_valid", 72'(out_valid), 72'd0);
        #6;
        send4(5, 5, 5, 5);
        idle(2);

        // gaps between products
        exp_q.push_back(72'd10);
        send(1);
        @(negedge clk);
        check("gap1_elem_idx", 72'(elem_idx), 72'd1);
        #6;
        send(2);
        @(negedge clk);
        check("gap2_elem_idx", 72'(elem_idx), 72'd2);
        #6;
        send(3); send(4);
        idle(2);

`ifdef DOT_ACC64_CLEAR_EN
        send(1); send(2);
        clr      = 1'b1;
        product  = 64'd9;
        valid_in = 1'b1;
        @(negedge clk);
        check("clr_in_ready", 72'(in_ready), 72'd0);
        @(posedge clk);
        #1;
        clr      = 1'b0;
        valid_in = 1'b0;
        @(negedge clk);
        check("clr_elem_idx", 72'(elem_idx), 72'd0);
        #6;
        send4(1, 1, 1, 1);
        idle(2);
`endif

        idle(3);
        check("queue_drained", 72'(exp_q.size()), 72'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
